pma_region_table: RTL
=====================

PMA_REGION_TABLE -- requirements
Module: pma_region_table

Interface
REQ-001 SHALL have parameter NrRules, default 4, number of address-region rules (1..16).
REQ-002 SHALL have parameter AddrWidth, default 64, physical address width.
REQ-003 SHALL have parameter RstBase, default all-zero, NrRules x AddrWidth packed reset bases.
REQ-004 SHALL have parameter RstLength, default all-zero, NrRules x AddrWidth packed reset lengths.
REQ-005 SHALL have parameter RstAttr, default all-zero, NrRules x 3 packed reset attributes {exec, non_idem, cached}.
REQ-006 SHALL have parameter DefaultAttr, default 3'b000, attribute returned on miss.
REQ-007 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-009 SHALL have port cfg_req_i, input, 1, config access request.
REQ-010 SHALL have port cfg_we_i, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port cfg_idx_i, input, $clog2(NrRules) (min 1), rule index.
REQ-012 SHALL have port cfg_field_i, input, 2, 0 = base, 1 = length, 2 = attr/lock, 3 = reserved.
REQ-013 SHALL have port cfg_wdata_i, input, AddrWidth, write data; attr field uses bits [2:0], lock uses bit 7.
REQ-014 SHALL have port cfg_rvalid_o, output, 1, response valid one cycle after cfg_req_i.
REQ-015 SHALL have ports cfg_rdata_o, output, AddrWidth, read data, and cfg_err_o, output, 1, access error.
REQ-016 SHALL have ports lu_valid_i, input, 1, lookup request, and lu_addr_i, input, AddrWidth, lookup address.
REQ-017 SHALL have ports lu_valid_o, output, 1; lu_hit_o, output, 1; lu_attr_o, output, 3; lu_rule_o, output, $clog2(NrRules) (min 1) -- the registered lookup result.

Function
REQ-018 Rule i SHALL match address a when length_i != 0 and base_i <= a < base_i + length_i.
- The sum SHALL be computed in AddrWidth+1 bits, so regions ending at 2^AddrWidth do not wrap.
REQ-019 On multiple matches, the lowest-index matching rule SHALL win.
REQ-020 A lookup SHALL have exactly one cycle of latency.
- lu_valid_o(t+1) = lu_valid_i(t).
- lu_hit_o, lu_attr_o and lu_rule_o SHALL be registered and SHALL hold their values while lu_valid_o = 0.
REQ-021 On a miss, the block SHALL return lu_hit_o = 0, lu_attr_o = DefaultAttr and lu_rule_o = 0.
REQ-022 A lookup in the same cycle as a write SHALL use the pre-write table contents.
REQ-023 Config accesses are always accepted, with no backpressure. cfg_rvalid_o SHALL pulse one cycle after each cfg_req_i, and back-to-back requests are allowed.
REQ-024 A read SHALL return the selected field zero-extended. The attr field reads as {lock at bit 7, attr at [2:0]}.
REQ-025 A write SHALL update the field at the clock edge of the request cycle.
REQ-026 A write to a rule whose lock = 1 SHALL leave state unchanged and SHALL set cfg_err_o = 1 in the response cycle.
REQ-027 A write to the attr field with bit 7 = 1 SHALL set lock. Lock SHALL be clearable only by reset.
REQ-028 An access with cfg_idx_i >= NrRules or cfg_field_i = 3 SHALL have no side effect and SHALL return rdata = 0 and err = 1.
REQ-029 cfg_err_o and cfg_rdata_o SHALL be 0 whenever cfg_rvalid_o = 0.

Reset
REQ-030 When rst_ni = 0 at a clock edge, the table SHALL load from the parameters:
- base from RstBase, length from RstLength, attr from RstAttr;
- all locks cleared.
REQ-031 The same reset edge SHALL clear the outputs:
- lu_valid_o = 0, lu_hit_o = 0, lu_attr_o = DefaultAttr, lu_rule_o = 0;
- cfg_rvalid_o = 0, cfg_rdata_o = 0, cfg_err_o = 0.
REQ-032 A reset asserted mid-operation SHALL discard any in-flight lookup or config response; no pulse SHALL appear after reset release.

Verification
REQ-033 Test overlap priority:
- Stimulus: write rule0 = {base 0x8000_0000, len 0x4000_0000, attr 3'b101}; rule1 = {base 0x8000_0000, len 0x1000, attr 3'b010}; lookup 0x8000_0800.
- Required response: next cycle lu_hit_o = 1, lu_rule_o = 0, lu_attr_o = 3'b101.
REQ-034 Test region bounds:
- Stimulus: lookup 0xBFFF_FFFF, then 0xC000_0000.
- Required response: hit, then miss with lu_attr_o = DefaultAttr.
REQ-035 Test lock:
- Stimulus: write rule2 attr = 0x84; then write rule2 base = 0x1234.
- Required response: second write gives cfg_err_o = 1; a read of rule2 base returns the old value; a read of the attr field returns 0x84.
REQ-036 Test the top-of-address-space boundary:
- Stimulus: rule3 = {base 0xFFFF_FFFF_FFFF_F000, len 0x1000}; lookup 0xFFFF_FFFF_FFFF_FFFF.
- Required response: hit on rule 3 (no wrap).
REQ-037 Test write/lookup collision:
- Stimulus: same-cycle write of rule0 len = 0 and lookup 0x8000_0000.
- Required response: hit on rule 0; the following cycle's lookup misses.
REQ-038 Test mid-operation reset:
- Stimulus: assert rst_ni = 0 in the cycle after a lookup and a config read.
- Required response: lu_valid_o = 0, cfg_rvalid_o = 0; the table equals the Rst* parameters and all locks are clear.

Source files
------------

// File: rtl/pma_region_table.sv
`default_nettype none
// ============================================================================
// Module      : pma_region_table
// Description : Configurable physical-memory-attribute region table. Each rule
//               holds a base address, a length, a 3-bit attribute
//               {exec, non_idem, cached} and a sticky lock bit. A lookup
//               returns the attribute of the lowest-index matching rule
//               after one cycle. A config port reads and writes the rules.
// Revision    : 1.0 - initial release
// ============================================================================
module pma_region_table #(
    parameter int unsigned                  NrRules     = 4,
    parameter int unsigned                  AddrWidth   = 64,
    parameter logic [NrRules*AddrWidth-1:0] RstBase     = '0,
    parameter logic [NrRules*AddrWidth-1:0] RstLength   = '0,
    parameter logic [NrRules*3-1:0]         RstAttr     = '0,
    parameter logic [2:0]                   DefaultAttr = 3'b000,
    localparam int unsigned                 c_IDX_W     = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // configuration port
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [c_IDX_W-1:0]   cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    // lookup port
    input  logic                 lu_valid_i,
    input  logic [AddrWidth-1:0] lu_addr_i,
    output logic                 lu_valid_o,
    output logic                 lu_hit_o,
    output logic [2:0]           lu_attr_o,
    output logic [c_IDX_W-1:0]   lu_rule_o
);

    localparam logic [1:0] c_FIELD_BASE = 2'd0;
    localparam logic [1:0] c_FIELD_LEN  = 2'd1;
    localparam logic [1:0] c_FIELD_ATTR = 2'd2;

    // rule storage
    logic [AddrWidth-1:0] r_base [NrRules];
    logic [AddrWidth-1:0] r_len  [NrRules];
    logic [2:0]           r_attr [NrRules];
    logic [NrRules-1:0]   r_lock;

    // registered lookup result
    logic                 r_lu_valid;
    logic                 r_lu_hit;
    logic [2:0]           r_lu_attr;
    logic [c_IDX_W-1:0]   r_lu_rule;

    // registered config response
    logic                 r_cfg_rvalid;
    logic [AddrWidth-1:0] r_cfg_rdata;
    logic                 r_cfg_err;

    // combinational lookup / decode
    logic [NrRules-1:0]   w_match;
    logic                 w_hit;
    logic [2:0]           w_attr;
    logic [c_IDX_W-1:0]   w_rule;
    logic                 w_idx_ok;
    logic                 w_acc_ok;
    logic                 w_sel_lock;
    logic                 w_wr;
    logic                 w_err;
    logic [AddrWidth-1:0] w_rdata;

    // Per-rule match; the end address is one bit wider so a region reaching
    // the top of the address space does not wrap to zero.
    for (genvar gi = 0; gi < int'(NrRules); gi++) begin : g_match
        logic [AddrWidth:0] w_end;
        assign w_end       = {1'b0, r_base[gi]} + {1'b0, r_len[gi]};
        assign w_match[gi] = (r_len[gi] != '0) &&
                             (lu_addr_i >= r_base[gi]) &&
                             ({1'b0, lu_addr_i} < w_end);
    end

    // Priority select: scanning downward leaves the lowest matching index.
    always_comb begin
        w_hit  = 1'b0;
        w_attr = DefaultAttr;
        w_rule = '0;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit  = 1'b1;
                w_attr = r_attr[i];
                w_rule = c_IDX_W'(i);
            end
        end
    end

    // Config access decode: range/field validity, lock check and read mux.
    always_comb begin
        w_idx_ok   = ({1'b0, cfg_idx_i} < (c_IDX_W+1)'(NrRules));
        w_acc_ok   = w_idx_ok && (cfg_field_i != 2'd3);
        w_sel_lock = w_idx_ok ? r_lock[cfg_idx_i] : 1'b0;
        w_wr       = cfg_req_i && cfg_we_i && w_acc_ok && !w_sel_lock;
        w_err      = !w_acc_ok || (cfg_we_i && w_sel_lock);
        w_rdata    = '0;
        if (w_acc_ok && !cfg_we_i) begin
            case (cfg_field_i)
                c_FIELD_BASE: w_rdata = r_base[cfg_idx_i];
                c_FIELD_LEN:  w_rdata = r_len[cfg_idx_i];
                c_FIELD_ATTR: begin
                    w_rdata[7]   = r_lock[cfg_idx_i];
                    w_rdata[2:0] = r_attr[cfg_idx_i];
                end
                default:      w_rdata = '0;
            endcase
        end
    end

    // Rule table: parameter image on reset, otherwise unlocked field writes.
    // Lock is only ever set here; a locked rule never reaches this write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                r_base[i] <= RstBase[i*AddrWidth +: AddrWidth];
                r_len[i]  <= RstLength[i*AddrWidth +: AddrWidth];
                r_attr[i] <= RstAttr[i*3 +: 3];
            end
            r_lock <= '0;
        end else if (w_wr) begin
            case (cfg_field_i)
                c_FIELD_BASE: r_base[cfg_idx_i] <= cfg_wdata_i;
                c_FIELD_LEN:  r_len[cfg_idx_i]  <= cfg_wdata_i;
                c_FIELD_ATTR: begin
                    r_attr[cfg_idx_i] <= cfg_wdata_i[2:0];
                    r_lock[cfg_idx_i] <= cfg_wdata_i[7];
                end
                default: ;
            endcase
        end
    end

    // Lookup result register; result fields hold while no lookup arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lu_valid <= 1'b0;
            r_lu_hit   <= 1'b0;
            r_lu_attr  <= DefaultAttr;
            r_lu_rule  <= '0;
        end else begin
            r_lu_valid <= lu_valid_i;
            if (lu_valid_i) begin
                r_lu_hit  <= w_hit;
                r_lu_attr <= w_attr;
                r_lu_rule <= w_rule;
            end
        end
    end

    // Config response register; data and error are zero outside a response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_rvalid <= cfg_req_i;
            r_cfg_rdata  <= cfg_req_i ? w_rdata : '0;
            r_cfg_err    <= cfg_req_i && w_err;
        end
    end

    assign lu_valid_o   = r_lu_valid;
    assign lu_hit_o     = r_lu_hit;
    assign lu_attr_o    = r_lu_attr;
    assign lu_rule_o    = r_lu_rule;
    assign cfg_rvalid_o = r_cfg_rvalid;
    assign cfg_rdata_o  = r_cfg_rdata;
    assign cfg_err_o    = r_cfg_err;

endmodule
`default_nettype wire
